uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared 8N1 receiver definitions: FSM encoding, oversampling constants and helpers.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned BIT_CNT_W  = 3;

  localparam logic [IDX_W-1:0]     IDX_SAMPLE_A = 4'd7;
  localparam logic [IDX_W-1:0]     IDX_SAMPLE_B = 4'd8;
  localparam logic [IDX_W-1:0]     IDX_DECIDE   = 4'd9;
  localparam logic [IDX_W-1:0]     IDX_LAST     = 4'd15;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_STOP     = 3'd3,
    ST_BRK_WAIT = 3'd4
  } rx_state_e;

  // Rounded clocks per oversample tick.
  function automatic int unsigned os_div_calc(input int unsigned clk_freq,
                                              input int unsigned baud);
    return (clk_freq + baud * 8) / (baud * OVERSAMPLE);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every DIV clks, restartable via clear.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, hold-until-ack output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned OS_DIV = os_div_calc(CLK_FREQ, BAUD);

  rx_state_e state_q, state_d;

  logic                 sync1_q, rx_s_q, rx_prev_q;
  logic                 os_tick;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic fall_edge, start_det, vote, decide, bit_end, good_stop;

  // Metastability synchronizer plus one extra copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_pin;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_s_q;
  assign start_det = (state_q == ST_IDLE) & fall_edge;

  uart_baud_tick #(
    .DIV (OS_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (start_det),
    .tick  (os_tick)
  );

  assign vote      = majority3(samp_a_q, samp_b_q, rx_s_q);
  assign decide    = os_tick & (idx_q == IDX_DECIDE);
  assign bit_end   = os_tick & (idx_q == IDX_LAST);
  assign good_stop = (state_q == ST_STOP) & decide & vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (fall_edge) state_d = ST_START;
      ST_START: begin
        if (decide && vote)  state_d = ST_IDLE;
        else if (bit_end)    state_d = ST_DATA;
      end
      ST_DATA:     if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = ST_STOP;
      ST_STOP:     if (decide) state_d = vote ? ST_IDLE : ST_BRK_WAIT;
      ST_BRK_WAIT: if (os_tick && rx_s_q && (idx_q == IDX_LAST)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; in BRK_WAIT the index counts consecutive high ticks.
  always_comb begin
    idx_d       = idx_q;
    bit_cnt_d   = bit_cnt_q;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    busy_d      = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);

    if (state_q == ST_IDLE) begin
      idx_d     = '0;
      bit_cnt_d = '0;
    end else if (state_q == ST_BRK_WAIT) begin
      if (os_tick) idx_d = rx_s_q ? (idx_q + IDX_W'(1)) : '0;
    end else if (os_tick) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_SAMPLE_A) samp_a_d = rx_s_q;
      if (idx_q == IDX_SAMPLE_B) samp_b_d = rx_s_q;
    end

    if ((state_q == ST_STOP) && (state_d == ST_BRK_WAIT)) idx_d = '0;
    if ((state_q == ST_DATA) && bit_end) bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    if ((state_q == ST_DATA) && decide)  shreg_d = {vote, shreg_q[DATA_BITS-1:1]};

    if (rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // A same-clk ack retires the old byte, so delivery takes precedence over overrun.
    if (good_stop) begin
      if (!valid_q || rx_ack) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if ((state_q == ST_STOP) && decide && !vote) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      bit_cnt_q   <= '0;
      samp_a_q    <= 1'b0;
      samp_b_q    <= 1'b0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 625 kbaud (OS_DIV = 10, 160 clks per bit).
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 625_000;
  localparam real         BIT_NOM  = 1600.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       man_ack = 1'b0;
  logic       auto_ack = 1'b0;
  logic       auto_en = 1'b0;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

  int         total = 0;
  int         bad = 0;
  int         err_hi = 0;
  logic [7:0] got_q[$];

  assign rx_ack = man_ack | auto_ack;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_frame_err === 1'b1) err_hi++;

  // Consumer that takes every delivered byte with a one-clk ack.
  always @(negedge clk) begin
    if (auto_ack) begin
      auto_ack = 1'b0;
    end else if (auto_en && rx_valid === 1'b1) begin
      got_q.push_back(rx_data);
      auto_ack = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input real bt);
    rx_pin = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      #(bt);
    end
    rx_pin = stop_v;
    #(bt);
  endtask

  task automatic do_ack();
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    real        skews[3];
    logic [7:0] exp5[4];
    logic [7:0] g;
    real        bt;
    skews = '{1.0, 1.02, 0.98};
    exp5  = '{8'h00, 8'hFF, 8'hAA, 8'h0F};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr", 32'(rx_frame_err), 32'h0);
    chk("rst_ovr", 32'(rx_overrun), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, held until ack
    send_byte(8'hA5, 1'b1, BIT_NOM);
    #(BIT_NOM);
    @(negedge clk);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_valid", 32'(rx_valid), 32'h1);
    chk("a5_ferr_cnt", 32'(err_hi), 32'd0);
    chk("a5_ovr", 32'(rx_overrun), 32'h0);
    chk("a5_busy", 32'(rx_busy), 32'h0);
    do_ack();
    chk("a5_ack_valid", 32'(rx_valid), 32'h0);
    chk("a5_ack_data", 32'(rx_data), 32'hA5);

    // Short low glitch: false start
    @(negedge clk);
    rx_pin = 1'b0;
    #200;
    chk("glitch_busy_hi", 32'(rx_busy), 32'h1);
    #200;
    rx_pin = 1'b1;
    #(BIT_NOM);
    @(negedge clk);
    chk("glitch_busy_lo", 32'(rx_busy), 32'h0);
    chk("glitch_valid", 32'(rx_valid), 32'h0);
    chk("glitch_ferr_cnt", 32'(err_hi), 32'd0);

    // Framing error followed by a break
    send_byte(8'h3C, 1'b0, BIT_NOM);
    #(3.0 * BIT_NOM);
    @(negedge clk);
    chk("brk_ferr_cnt", 32'(err_hi), 32'd1);
    chk("brk_valid", 32'(rx_valid), 32'h0);
    chk("brk_busy", 32'(rx_busy), 32'h0);
    rx_pin = 1'b1;
    #(0.5 * BIT_NOM);
    rx_pin = 1'b0;
    #200;
    @(negedge clk);
    chk("brk_blocks_start", 32'(rx_busy), 32'h0);
    #200;
    rx_pin = 1'b1;
    #(2.0 * BIT_NOM);
    send_byte(8'h55, 1'b1, BIT_NOM);
    #(BIT_NOM);
    @(negedge clk);
    chk("post_brk_data", 32'(rx_data), 32'h55);
    chk("post_brk_valid", 32'(rx_valid), 32'h1);
    chk("post_brk_ferr_cnt", 32'(err_hi), 32'd1);
    do_ack();

    // Overrun
    send_byte(8'h11, 1'b1, BIT_NOM);
    send_byte(8'h22, 1'b1, BIT_NOM);
    #(BIT_NOM);
    @(negedge clk);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_flag", 32'(rx_overrun), 32'h1);
    do_ack();
    chk("ovr_ack_valid", 32'(rx_valid), 32'h0);
    chk("ovr_ack_flag", 32'(rx_overrun), 32'h0);
    chk("ovr_ack_data", 32'(rx_data), 32'h11);

    // Back-to-back bytes at nominal and +/-2% sender rate
    auto_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bt = BIT_NOM / skews[k];
      got_q.delete();
      for (int i = 0; i < 4; i++) send_byte(exp5[i], 1'b1, bt);
      #(2.0 * bt);
      @(negedge clk);
      chk($sformatf("b2b%0d_count", k), 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        chk($sformatf("b2b%0d_byte%0d", k, i), 32'(g), 32'(exp5[i]));
      end
    end
    auto_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_ferr_cnt", 32'(err_hi), 32'd1);

    // Reset mid-frame
    send_byte(8'h77, 1'b1, BIT_NOM);
    #(BIT_NOM);
    @(negedge clk);
    chk("pre_rst_valid", 32'(rx_valid), 32'h1);
    fork
      send_byte(8'h5A, 1'b1, BIT_NOM);
      begin
        #(3.5 * BIT_NOM);
        rst = 1'b1;
        #1;
        chk("midrst_data", 32'(rx_data), 32'h00);
        chk("midrst_valid", 32'(rx_valid), 32'h0);
        chk("midrst_busy", 32'(rx_busy), 32'h0);
        chk("midrst_ovr", 32'(rx_overrun), 32'h0);
        chk("midrst_ferr", 32'(rx_frame_err), 32'h0);
        #(BIT_NOM);
        rst = 1'b0;
      end
    join
    #(12.0 * BIT_NOM);
    @(negedge clk);
    if (rx_valid === 1'b1) do_ack();
    send_byte(8'hC3, 1'b1, BIT_NOM);
    #(BIT_NOM);
    @(negedge clk);
    chk("post_rst_data", 32'(rx_data), 32'hC3);
    chk("post_rst_valid", 32'(rx_valid), 32'h1);
    chk("post_rst_ovr", 32'(rx_overrun), 32'h0);
    do_ack();
    chk("post_rst_ack_valid", 32'(rx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
